// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
//   state_t      : controller states (IDLE / RUN / DONE)
//   ERR_QUOTIENT : all-ones quotient reported on divide-by-zero or overflow;
//                  users slice the low WIDTH bits (WIDTH <= MAX_WIDTH)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ERR_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
//   minuend    : shifted partial remainder, WIDTH+1 bits
//   subtrahend : zero-extended divisor, WIDTH+1 bits
//   diff       : minuend - subtrahend (WIDTH+1 bits, wraps on borrow)
//   borrow     : 1 when minuend < subtrahend
module div_trial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   start                 : request, accepted only in IDLE
//   dividend, divisor     : operands, latched on the accepting edge
//   busy                  : high while iterating
//   done                  : one-cycle pulse, results valid from this cycle
//   quotient, remainder   : results, held until the next completion
//   div_by_zero, overflow : error flags of the last operation
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t         state, state_next;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] div_hi, div_lo;
  logic             err_zero, err_ovf, last_iter;
  logic [WIDTH:0]   trial_min, trial_diff, rem_next;
  logic             trial_borrow;
  logic [WIDTH-1:0] q_next;

  assign div_hi    = dividend[2*WIDTH-1:WIDTH];
  assign div_lo    = dividend[WIDTH-1:0];
  assign err_zero  = (divisor == '0);
  assign err_ovf   = !err_zero && (div_hi >= divisor);
  assign last_iter = (cnt == CW'(WIDTH-1));

  // The partial remainder always stays below the divisor, so its top bit is
  // never needed to form the next trial minuend.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign trial_min = {rem[WIDTH-1:0], q_sr[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .minuend    (trial_min),
    .subtrahend ({1'b0, dvsr}),
    .diff       (trial_diff),
    .borrow     (trial_borrow)
  );

  assign rem_next = trial_borrow ? trial_min : trial_diff;
  assign q_next   = {q_sr[WIDTH-2:0], ~trial_borrow};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (err_zero || err_ovf) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      q_sr        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dvsr        <= divisor;
            cnt         <= '0;
            rem         <= {1'b0, div_hi};
            q_sr        <= div_lo;
            div_by_zero <= err_zero;
            overflow    <= err_ovf;
            // Error results are published immediately since DONE follows.
            if (err_zero || err_ovf) begin
              quotient  <= ERR_QUOTIENT[WIDTH-1:0];
              remainder <= div_lo;
            end
          end
        end
        S_RUN: begin
          rem  <= rem_next;
          q_sr <= q_next;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
